mem_req_ctrl: RTL

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl_if.sv | 41 ++++
 rtl/mem_req_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: load/store-stage controls and data-bus handshake of mem_req_ctrl.
// master = the controller (drives the data bus), slave = pipeline stage + memory side.
interface mem_req_ctrl_if;
    logic        ls_valid_i;
    logic        ls_load_i;
    logic        ls_store_i;
    logic        ls_sign_i;
    logic [2:0]  ls_size_i;
    logic [31:0] ls_addr_i;
    logic [31:0] ls_wdata_i;
    logic        flush_i;
    logic        allowin_i;
    logic        ls_over_o;
    logic [31:0] ls_rdata_o;
    logic        ls_ale_o;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [3:0]  data_wstrb_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;

    modport master (
        input  ls_valid_i, ls_load_i, ls_store_i, ls_sign_i, ls_size_i,
        input  ls_addr_i, ls_wdata_i, flush_i, allowin_i,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i,
        output ls_over_o, ls_rdata_o, ls_ale_o,
        output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_wstrb_o
    );

    modport slave (
        output ls_valid_i, ls_load_i, ls_store_i, ls_sign_i, ls_size_i,
        output ls_addr_i, ls_wdata_i, flush_i, allowin_i,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i,
        input  ls_over_o, ls_rdata_o, ls_ale_o,
        input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wdata_o, data_wstrb_o
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: MEM-stage load/store request controller, one outstanding bus request.
// Optional feature macro MEM_ALIGN_CHECK_EN: misaligned accesses are rejected with
// ls_ale_o instead of being issued with a force-aligned address.
module mem_req_ctrl (
    input  logic           clk,
    input  logic           rst,
    mem_req_ctrl_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [2:0] SZ_BYTE = 3'd4;
    localparam logic [2:0] SZ_HALF = 3'd2;

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic          sign_q;
    logic          capture;
    logic          is_ls;
    logic          is_byte;
    logic          is_half;
    logic          misaligned;
    logic          align_block;
    logic          start;
    logic [1:0]    size_enc;
    logic [AW-1:0] addr_al;
    logic [3:0]    wstrb_nxt;
    logic [DW-1:0] wdata_nxt;
    logic [DW-1:0] rdata_sh;
    logic [DW-1:0] rdata_ext;

    // Decode the incoming instruction into bus request fields
    always_comb begin
        is_ls      = bus.ls_load_i | bus.ls_store_i;
        is_byte    = (bus.ls_size_i == SZ_BYTE);
        is_half    = (bus.ls_size_i == SZ_HALF);
        misaligned = is_half ? bus.ls_addr_i[0]
                   : (is_byte ? 1'b0 : (bus.ls_addr_i[1:0] != 2'b00));
        size_enc   = is_byte ? 2'd0 : (is_half ? 2'd1 : 2'd2);
        addr_al    = bus.ls_addr_i;
        if (misaligned) begin
            if (is_half) addr_al[0]   = 1'b0;
            else         addr_al[1:0] = 2'b00;
        end
        wdata_nxt = bus.ls_wdata_i;
        wstrb_nxt = 4'b1111;
        if (is_byte) begin
            wdata_nxt = {4{bus.ls_wdata_i[7:0]}};
            wstrb_nxt = 4'b0001 << addr_al[1:0];
        end else if (is_half) begin
            wdata_nxt = {2{bus.ls_wdata_i[15:0]}};
            wstrb_nxt = addr_al[1] ? 4'b1100 : 4'b0011;
        end
        if (!bus.ls_store_i) wstrb_nxt = 4'b0000;
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign align_block  = misaligned;
    assign bus.ls_ale_o = ~rst & (state_q == S_IDLE) & bus.ls_valid_i & is_ls & misaligned;
`else
    assign align_block  = 1'b0;
    assign bus.ls_ale_o = 1'b0;
`endif

    assign start = (state_q == S_IDLE) & bus.ls_valid_i & is_ls & ~align_block & ~bus.flush_i;

    // Completion: result held in DONE, or an instruction that needs no bus access
    assign bus.ls_over_o = ~rst & ((state_q == S_DONE) |
                           ((state_q == S_IDLE) & bus.ls_valid_i & (~is_ls | align_block)));

    // Extract and extend the returned load data using the registered request
    always_comb begin
        rdata_sh  = bus.data_rdata_i;
        rdata_ext = bus.data_rdata_i;
        if (bus.data_size_o == 2'd0) begin
            rdata_sh  = bus.data_rdata_i >> {bus.data_addr_o[1:0], 3'b000};
            rdata_ext = {{24{sign_q & rdata_sh[7]}}, rdata_sh[7:0]};
        end else if (bus.data_size_o == 2'd1) begin
            rdata_sh  = bus.data_rdata_i >> {bus.data_addr_o[1], 4'b0000};
            rdata_ext = {{16{sign_q & rdata_sh[15]}}, rdata_sh[15:0]};
        end
    end

    // Next-state logic; flush wins over progress, DRAIN absorbs an accepted request
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.flush_i) begin
                    state_d = (bus.data_addr_ok_i & ~bus.data_data_ok_i) ? S_DRAIN : S_IDLE;
                end else if (bus.data_addr_ok_i) begin
                    if (bus.data_data_ok_i) begin
                        state_d = S_DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.flush_i) begin
                    state_d = bus.data_data_ok_i ? S_IDLE : S_DRAIN;
                end else if (bus.data_data_ok_i) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.flush_i | bus.allowin_i) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.data_data_ok_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Request fields latched at start and held; load result latched on capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_req_o   <= 1'b0;
            bus.data_wr_o    <= 1'b0;
            bus.data_size_o  <= 2'd0;
            bus.data_addr_o  <= '0;
            bus.data_wdata_o <= '0;
            bus.data_wstrb_o <= 4'b0000;
            bus.ls_rdata_o   <= '0;
            sign_q           <= 1'b0;
        end else begin
            bus.data_req_o <= (state_d == S_REQ);
            if (start) begin
                bus.data_wr_o    <= bus.ls_store_i;
                bus.data_size_o  <= size_enc;
                bus.data_addr_o  <= addr_al;
                bus.data_wdata_o <= wdata_nxt;
                bus.data_wstrb_o <= wstrb_nxt;
                sign_q           <= bus.ls_sign_i;
            end
            if (capture) bus.ls_rdata_o <= rdata_ext;
        end
    end
endmodule
